// File: rtl/signed_divider.sv
// rtl/signed_divider.sv - iterative restoring signed/unsigned divider, one quotient bit per cycle
module signed_divider #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_is_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIX    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [N-1:0]  r_dvd;        // dividend magnitude, shifted out MSB-first; fills with quotient bits
  logic [N-1:0]  r_dsr;        // divisor magnitude
  logic [N-1:0]  r_rem;        // partial remainder (always < r_dsr or == dividend when r_dsr is 0)
  logic [CW-1:0] r_cnt;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_done;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;

  logic          w_neg_a;
  logic          w_neg_b;
  logic [N-1:0]  w_abs_a;
  logic [N-1:0]  w_abs_b;
  logic          w_accept;
  logic [N:0]    w_rem_shift;
  logic          w_ge;
  logic [N-1:0]  w_rem_sub;
  logic          w_busy;

  // Operand conditioning: signs and magnitudes of the incoming operands.
  always_comb begin
    w_neg_a = i_is_signed & i_dividend[N-1];
    w_neg_b = i_is_signed & i_divisor[N-1];
    w_abs_a = w_neg_a ? -i_dividend : i_dividend;
    w_abs_b = w_neg_b ? -i_divisor  : i_divisor;
  end

  // One restoring step: shift in the next dividend bit, then compare/subtract.
  // The shifted remainder needs N+1 bits; when the subtraction is taken the
  // true difference is below 2^N, so an N-bit subtract is exact.
  always_comb begin
    w_rem_shift = {r_rem, r_dvd[N-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_dsr});
    w_rem_sub   = w_rem_shift[N-1:0] - r_dsr;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a start seen during the done cycle is not accepted.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_start && !r_done) w_next_state = S_DIVIDE;
      S_DIVIDE: if (r_cnt == '0)        w_next_state = S_FIX;
      S_FIX:                            w_next_state = S_IDLE;
      default:                          w_next_state = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && i_start && !r_done;
  end

  // Datapath: latch operands, iterate, then re-apply signs into the result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd   <= w_abs_a;
            r_dsr   <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= CW'(N - 1);
            // Divide-by-zero yields an all-ones quotient whatever the signs.
            r_neg_q <= (w_neg_a ^ w_neg_b) & (|i_divisor);
            r_neg_r <= w_neg_a;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_shift[N-1:0];
          r_dvd <= {r_dvd[N-2:0], w_ge};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          r_quotient  <= r_neg_q ? -r_dvd : r_dvd;
          r_remainder <= r_neg_r ? -r_rem : r_rem;
        end
        default: ;
      endcase
    end
  end

  // Done pulses for the single cycle after the FIX state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
    end
  end

  assign o_busy      = w_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

endmodule

// File: tb/tb_signed_divider.sv
// tb/tb_signed_divider.sv - self-checking bench for signed_divider
module tb_signed_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic         i_is_signed;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;

  int n_checks = 0;
  int n_fail   = 0;

  signed_divider #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_is_signed (i_is_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, with the divide-by-zero rule.
  function automatic void model(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      q = N'(sa / sb);
      r = N'(sa % sb);
    end
  endfunction

  // Issue one operation; optionally fire a stray start 'intrude' cycles after acceptance.
  task automatic do_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, input int intrude,
                       output logic [N-1:0] q, output logic [N-1:0] r, output int lat, output int bcnt);
    @(negedge clk);
    while (o_done) @(negedge clk);
    i_start     = 1'b1;
    i_is_signed = s;
    i_dividend  = a;
    i_divisor   = b;
    @(posedge clk); #1;
    i_start     = 1'b0;
    i_dividend  = $urandom;
    i_divisor   = $urandom;
    i_is_signed = 1'($urandom_range(0, 1));
    lat  = 0;
    bcnt = 0;
    while (!o_done && lat < 200) begin
      if (o_busy) bcnt++;
      if (lat == intrude) begin
        i_start    = 1'b1;
        i_dividend = $urandom;
        i_divisor  = $urandom;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    i_start = 1'b0;
    q = o_quotient;
    r = o_remainder;
  endtask

  task automatic run_expect(input string tag, input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] eq, input logic [N-1:0] er, input int intrude);
    logic [N-1:0] q;
    logic [N-1:0] r;
    int lat;
    int bcnt;
    do_op(s, a, b, intrude, q, r, lat, bcnt);
    check({tag, " quotient"},  q, eq);
    check({tag, " remainder"}, r, er);
    check({tag, " latency"},   N'(lat), N'(N + 1));
    check({tag, " busy_cycles"}, N'(bcnt), N'(N + 1));
    check({tag, " busy_at_done"}, N'(o_busy), N'(0));
  endtask

  task automatic run_model(input string tag, input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    model(s, a, b, eq, er);
    run_expect(tag, s, a, b, eq, er, -1);
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q_hold;
    logic [N-1:0] r_hold;
    logic s;

    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_is_signed = 1'b0;
    i_dividend  = '0;
    i_divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", N'(o_busy), N'(0));
    check("reset done", N'(o_done), N'(0));
    check("reset quotient", o_quotient, '0);
    check("reset remainder", o_remainder, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_expect("s 100/7",  1'b1, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, -1);
    run_expect("s -100/7", 1'b1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, -1);
    run_expect("s 100/-7", 1'b1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'h00000002, -1);
    run_expect("s 5/0",    1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005, -1);
    run_expect("u 5/0",    1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005, -1);
    run_expect("s -5/0",   1'b1, -32'sd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, -1);
    run_expect("s ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, -1);
    run_expect("u max/2",  1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'h00000001, -1);
    run_expect("s -1/2",   1'b1, 32'hFFFFFFFF, 32'd2, 32'h00000000, 32'hFFFFFFFF, -1);
    run_expect("s 0/-9",   1'b1, 32'd0, -32'sd9, 32'h00000000, 32'h00000000, -1);
    run_expect("s -3/40",  1'b1, -32'sd3, 32'd40, 32'h00000000, 32'hFFFFFFFD, -1);

    // Stray start five cycles into an operation must not disturb it.
    run_expect("intrude 100/7", 1'b1, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 5);

    // Start during the done cycle is ignored; done is one cycle and results hold.
    q_hold      = o_quotient;
    r_hold      = o_remainder;
    i_start     = 1'b1;
    i_is_signed = 1'b0;
    i_dividend  = 32'd77;
    i_divisor   = 32'd5;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("done-cycle start busy", N'(o_busy), N'(0));
    check("done pulse width", N'(o_done), N'(0));
    repeat (3) @(posedge clk);
    #1;
    check("hold quotient",  o_quotient, 32'h0000000E);
    check("hold remainder", o_remainder, 32'h00000002);

    // Back-to-back: next start lands on the cycle after done.
    run_expect("b2b first",  1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, -1);
    run_expect("b2b second", 1'b1, -32'sd1000, 32'd33, -32'sd30, -32'sd10, -1);

    // Randomised operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = N'($urandom_range(1, 300)); end
        2: begin a = $urandom; b = '0; end
        default: begin
          a = N'($urandom_range(0, 50));
          b = $urandom;
          if ($urandom_range(0, 1) == 1) a = -a;
        end
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      run_model($sformatf("rand%0d", i), s, a, b);
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    i_start     = 1'b1;
    i_is_signed = 1'b1;
    i_dividend  = 32'd123456;
    i_divisor   = 32'd77;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset busy", N'(o_busy), N'(0));
    check("midreset done", N'(o_done), N'(0));
    check("midreset quotient", o_quotient, '0);
    check("midreset remainder", o_remainder, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_expect("post-reset 9/3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
